in_frame: RTL

IN_FRAME -- requirements
Module: in_frame

---
 rtl/in_frame.sv | 76 +++++++
 1 files changed

// File: rtl/in_frame.sv
// in_frame: loads a 25-word frame into the 5x5x64 state memory m1 and hands it to the core
module in_frame (
    input  logic        clk,
    input  logic        rst,
    input  logic        pushin,
    input  logic        firstin,
    input  logic [63:0] din,
    output logic        stopin,
    output logic [2:0]  m1wx,
    output logic [2:0]  m1wy,
    output logic [63:0] m1wd,
    output logic        m1wr,
    output logic        start,
    input  logic        done,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, FILL, FULL, WAIT} state_t;

    state_t     r_state;
    logic [4:0] r_wcnt;
    logic       w_acc;
    logic       w_wr;
    logic [4:0] w_idx;

    // Backpressure depends only on the registered state.
    assign stopin = (r_state == FULL) || (r_state == WAIT);
    assign w_acc  = pushin && !stopin;
    // A firstin word always restarts at (0,0); otherwise only FILL stores words.
    assign w_wr   = w_acc && (firstin || r_state == FILL);
    assign w_idx  = firstin ? 5'd0 : r_wcnt;

    // Frame FSM with registered write port, start and err pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_wcnt  <= 5'd0;
            m1wr    <= 1'b0;
            m1wx    <= 3'd0;
            m1wy    <= 3'd0;
            m1wd    <= 64'd0;
            start   <= 1'b0;
            err     <= 1'b0;
        end else begin
            m1wr  <= w_wr;
            start <= 1'b0;
            err   <= w_acc && (firstin ? r_state == FILL : r_state == IDLE);
            if (w_wr) begin
                m1wx <= 3'(w_idx % 5'd5);
                m1wy <= 3'(w_idx / 5'd5);
                m1wd <= din;
            end
            case (r_state)
                IDLE: begin
                    if (w_wr) begin
                        r_wcnt  <= 5'd1;
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (w_wr) begin
                        if (w_idx == 5'd24) begin
                            r_wcnt  <= 5'd0;
                            r_state <= FULL;
                            start   <= 1'b1;
                        end else begin
                            r_wcnt <= w_idx + 5'd1;
                        end
                    end
                end
                FULL: r_state <= WAIT;
                WAIT: r_state <= done ? IDLE : WAIT;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
